regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter and hazard monitor for the single-write-port register file. Two producers share the one write port through a registered output stage: the ALU/jump path and the memory-load path. It also flags decode-stage read hazards against writes that are pending or in flight, so the pipeline controller can stall.

Parameters:
W, 32, data width of write-back values
RA_IDX, 31, register index forced when alu_link is set
CNT_W, 16, width of the saturating contention counter

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU write-back request
alu_rd  in  5  ALU destination index
alu_link  in  1  jal link write; overrides alu_rd with RA_IDX
alu_data  in  W  ALU write-back value
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load write-back request
mem_rd  in  5  load destination index
mem_data  in  W  load write-back value
mem_ready  out  1  load request accepted this cycle
rr1  in  5  decode read index 1, for the hazard check
rr2  in  5  decode read index 2, for the hazard check
haz1  out  1  rr1 has a pending or in-flight write
haz2  out  1  rr2 has a pending or in-flight write
rf_regwrite  out  1  register-file write enable
rf_wr  out  5  register-file write index
rf_wdata  out  W  register-file write data
conflict_cnt  out  CNT_W  cycles in which both requests were valid, saturating

Behaviour:
- Reset (synchronous, active-high, clock clock):
  - rf_regwrite=0, rf_wr=0, rf_wdata=0, conflict_cnt=0, last_mem=0.
  - An in-flight output write is discarded.
  - The ready outputs are combinational, so during reset they still follow the valids per the grant rules.
- Effective ALU index: ealu_rd = alu_link ? RA_IDX : alu_rd.
- Handshake:
  - A transfer occurs on a posedge when valid && ready.
  - A requester holds valid, rd and data stable until accepted. The bench asserts this.
  - The register file never back-pressures, so exactly one grant is issued whenever any valid is high.
- Grant (combinational):
  - Only alu_valid high -> alu_ready=1.
  - Only mem_valid high -> mem_ready=1.
  - Both high -> grant MEM if last_mem==0, otherwise grant ALU.
  - alu_ready and mem_ready are never both 1.
- Pointer: on every accepted transfer, last_mem <= (winner is MEM). This gives strict alternation under sustained contention, and MEM wins the first tie after reset.
- Output stage, latency 1:
  - A transfer accepted at posedge N drives rf_regwrite/rf_wr/rf_wdata during cycle N+1. The register file commits it at posedge N+1.
  - rf_regwrite=1 only if the accepted index != 0. Writes to r0 are accepted (ready=1) but dropped: rf_regwrite=0, and rf_wr/rf_wdata keep their prior values.
  - No transfer at posedge N -> rf_regwrite=0 in cycle N+1; rf_wr/rf_wdata hold.
- Hazards (combinational):
  - haz1 = (rr1!=0) && ((alu_valid && ealu_rd==rr1) || (mem_valid && mem_rd==rr1) || (rf_regwrite && rf_wr==rr1)).
  - haz2 is identical with rr2.
  - A loser waiting for a grant keeps flagging its hazard.
- conflict_cnt: +1 on each posedge with alu_valid && mem_valid and not in reset; saturates at all-ones.
- Both requesters targeting the same rd in the same cycle: serialized in grant order. The later grant's data is the final register value.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_regwrite=1, rf_wr=5, rf_wdata=0xDEADBEEF; haz1=1 while rr1=5 in both cycles.
- jal link: alu_link=1, alu_rd=7, alu_data=0x00400010 -> rf_wr=31, rf_wdata=0x00400010.
- Contention after reset: both valid for 4 cycles (ALU rd=3 data=1, MEM rd=3 data=2; each re-presents after its accept) -> grant order MEM, ALU, MEM, ALU; rf_wdata sequence 2,1,2,1; conflict_cnt=4.
- r0 drop: mem_valid=1, mem_rd=0 -> mem_ready=1; next cycle rf_regwrite=0; haz1=0 with rr1=0.
- Reset mid-operation: accept ALU rd=9, then assert reset at the next posedge -> rf_regwrite=0 after that edge, conflict_cnt=0, the next tie grants MEM.
- Saturation: CNT_W=4, both valid for 20 cycles -> conflict_cnt stops at 15.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single-write-port register file.
// Two producers (ALU/jump and memory-load) share the port through a
// one-cycle registered output stage. Decode-stage read hazards are
// flagged against requests waiting for the port and the write in flight.
module regfile_wb_arbiter #(
  parameter int unsigned W      = 32,
  parameter int unsigned RA_IDX = 31,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic             alu_link,
  input  logic [W-1:0]     alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [W-1:0]     mem_data,
  output logic             mem_ready,
  input  logic [4:0]       rr1,
  input  logic [4:0]       rr2,
  output logic             haz1,
  output logic             haz2,
  output logic             rf_regwrite,
  output logic [4:0]       rf_wr,
  output logic [W-1:0]     rf_wdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [4:0]       RA      = 5'(RA_IDX);

  logic         last_mem;
  logic [4:0]   ealu_rd;
  logic [4:0]   acc_rd;
  logic [W-1:0] acc_data;
  logic         xfer;

  // Grant selection and the winner's write-back payload.
  always_comb begin
    ealu_rd   = alu_link ? RA : alu_rd;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (alu_valid && mem_valid) begin
      mem_ready = !last_mem;
      alu_ready = last_mem;
    end else begin
      alu_ready = alu_valid;
      mem_ready = mem_valid;
    end
    xfer     = alu_ready || mem_ready;
    acc_rd   = mem_ready ? mem_rd : ealu_rd;
    acc_data = mem_ready ? mem_data : alu_data;
  end

  // A read index is hazardous if any request or the in-flight write targets it.
  always_comb begin
    haz1 = (rr1 != 5'd0) &&
           ((alu_valid && (ealu_rd == rr1)) ||
            (mem_valid && (mem_rd == rr1)) ||
            (rf_regwrite && (rf_wr == rr1)));
    haz2 = (rr2 != 5'd0) &&
           ((alu_valid && (ealu_rd == rr2)) ||
            (mem_valid && (mem_rd == rr2)) ||
            (rf_regwrite && (rf_wr == rr2)));
  end

  // Output stage, round-robin pointer and saturating contention counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_regwrite  <= 1'b0;
      rf_wr        <= 5'd0;
      rf_wdata     <= '0;
      conflict_cnt <= '0;
      last_mem     <= 1'b0;
    end else begin
      rf_regwrite <= 1'b0;
      if (xfer) begin
        last_mem <= mem_ready;
        // r0 writes are accepted but dropped; index/data hold their values.
        if (acc_rd != 5'd0) begin
          rf_regwrite <= 1'b1;
          rf_wr       <= acc_rd;
          rf_wdata    <= acc_data;
        end
      end
      if (alu_valid && mem_valid && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed cases with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clock, reset;
  logic        alu_valid, alu_link, mem_valid;
  logic [4:0]  alu_rd, mem_rd, rr1, rr2;
  logic [31:0] alu_data, mem_data;

  logic        alu_ready, mem_ready, haz1, haz2, rf_regwrite;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wdata;
  logic [15:0] conflict_cnt;

  logic        alu_ready_s, mem_ready_s, haz1_s, haz2_s, rf_regwrite_s;
  logic [4:0]  rf_wr_s;
  logic [31:0] rf_wdata_s;
  logic [3:0]  conflict_cnt_s;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_link(alu_link),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready), .rr1(rr1), .rr2(rr2), .haz1(haz1), .haz2(haz2),
    .rf_regwrite(rf_regwrite), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_link(alu_link),
    .alu_data(alu_data), .alu_ready(alu_ready_s),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready_s), .rr1(rr1), .rr2(rr2), .haz1(haz1_s), .haz2(haz2_s),
    .rf_regwrite(rf_regwrite_s), .rf_wr(rf_wr_s), .rf_wdata(rf_wdata_s),
    .conflict_cnt(conflict_cnt_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          known = 0;
  bit          m_prev_mem;   // previous accepted winner was the load path
  bit          m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wdata;
  int unsigned m_ties;

  function automatic logic [4:0] eff_alu();
    return alu_link ? 5'd31 : alu_rd;
  endfunction

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 0;
    return (alu_valid && eff_alu() == r) || (mem_valid && mem_rd == r) || (m_we && m_wr == r);
  endfunction

  // Compare every cycle at negedge, then advance the model to the next posedge.
  always @(negedge clock) begin
    bit e_alu, e_mem;
    e_mem = mem_valid && (!alu_valid || !m_prev_mem);
    e_alu = alu_valid && (!mem_valid || m_prev_mem);
    if (known) begin
      check("alu_ready", 32'(alu_ready), 32'(e_alu));
      check("mem_ready", 32'(mem_ready), 32'(e_mem));
      check("haz1", 32'(haz1), 32'(pending(rr1)));
      check("haz2", 32'(haz2), 32'(pending(rr2)));
      check("rf_regwrite", 32'(rf_regwrite), 32'(m_we));
      check("rf_wr", 32'(rf_wr), 32'(m_wr));
      check("rf_wdata", rf_wdata, m_wdata);
      check("conflict_cnt", 32'(conflict_cnt), (m_ties > 65535) ? 32'd65535 : m_ties);
      check("conflict_cnt_sat4", 32'(conflict_cnt_s), (m_ties > 15) ? 32'd15 : m_ties);
    end
    if (reset) begin
      known = 1; m_prev_mem = 0; m_we = 0; m_wr = '0; m_wdata = '0; m_ties = 0;
    end else if (known) begin
      logic [4:0]  rd;
      logic [31:0] d;
      m_we = 0;
      if (e_alu || e_mem) begin
        rd = e_mem ? mem_rd : eff_alu();
        d  = e_mem ? mem_data : alu_data;
        m_prev_mem = e_mem;
        if (rd != 5'd0) begin
          m_we = 1; m_wr = rd; m_wdata = d;
        end
      end
      if (alu_valid && mem_valid) m_ties++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input bit al, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_link = al; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic idle();
    drive(0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    bit a_acc, m_acc;
    idle(); rr1 = '0; rr2 = '0; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // ALU only
    drive(1, 5'd5, 0, 32'hDEADBEEF, 0, 5'd0, 32'd0); rr1 = 5'd5;
    neg(); check("alu_only_ready", 32'(alu_ready), 32'd1);
    check("alu_only_haz1_req", 32'(haz1), 32'd1);
    cyc(); idle();
    neg(); check("alu_only_we", 32'(rf_regwrite), 32'd1);
    check("alu_only_wr", 32'(rf_wr), 32'd5);
    check("alu_only_wdata", rf_wdata, 32'hDEADBEEF);
    check("alu_only_haz1_flight", 32'(haz1), 32'd1);

    // jal link
    cyc(); drive(1, 5'd7, 1, 32'h00400010, 0, 5'd0, 32'd0); rr1 = 5'd0;
    neg(); check("jal_ready", 32'(alu_ready), 32'd1);
    cyc(); idle();
    neg(); check("jal_wr", 32'(rf_wr), 32'd31);
    check("jal_wdata", rf_wdata, 32'h00400010);

    // contention after reset
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    neg(); check("rst_cnt", 32'(conflict_cnt), 32'd0);
    check("rst_we", 32'(rf_regwrite), 32'd0);
    cyc(); drive(1, 5'd3, 0, 32'd1, 1, 5'd3, 32'd2);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("tie_mem_ready", 32'(mem_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("tie_alu_ready", 32'(alu_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) check("tie_wdata", rf_wdata, ((i - 1) % 2 == 0) ? 32'd2 : 32'd1);
      cyc();
      if (i == 3) idle();
    end
    neg(); check("tie_final_wdata", rf_wdata, 32'd1);
    check("tie_final_wr", 32'(rf_wr), 32'd3);
    check("tie_cnt", 32'(conflict_cnt), 32'd4);

    // r0 drop
    cyc(); drive(0, 5'd0, 0, 32'd0, 1, 5'd0, 32'h55); rr1 = 5'd0;
    neg(); check("r0_ready", 32'(mem_ready), 32'd1);
    check("r0_haz1", 32'(haz1), 32'd0);
    cyc(); idle();
    neg(); check("r0_we", 32'(rf_regwrite), 32'd0);
    check("r0_wdata_hold", rf_wdata, 32'd1);

    // reset mid-operation discards the in-flight write
    cyc(); drive(1, 5'd9, 0, 32'h99, 0, 5'd0, 32'd0);
    neg();
    cyc(); idle(); reset = 1'b1;
    neg(); check("mid_inflight_wr", 32'(rf_wr), 32'd9);
    cyc(); reset = 1'b0;
    neg(); check("mid_rst_we", 32'(rf_regwrite), 32'd0);
    check("mid_rst_wr", 32'(rf_wr), 32'd0);
    check("mid_rst_cnt", 32'(conflict_cnt), 32'd0);

    // MEM wins, reset, then the next tie must go to MEM again; then saturate
    cyc(); drive(0, 5'd0, 0, 32'd0, 1, 5'd4, 32'h44);
    neg();
    cyc(); idle(); reset = 1'b1;
    cyc(); reset = 1'b0; drive(1, 5'd6, 0, 32'h66, 1, 5'd8, 32'h88);
    neg(); check("post_rst_tie_mem", 32'(mem_ready), 32'd1);
    check("post_rst_tie_alu", 32'(alu_ready), 32'd0);
    for (int i = 0; i < 20; i++) cyc();
    idle();
    neg(); check("sat4_cnt", 32'(conflict_cnt_s), 32'd15);
    check("sat16_cnt", 32'(conflict_cnt), 32'd20);

    // randomized traffic; requesters hold until accepted
    cyc();
    for (int n = 0; n < 3000; n++) begin
      neg();
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      cyc();
      reset = ($urandom_range(0, 149) == 0);
      if (!alu_valid || a_acc) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = rnd_idx();
        alu_link  = ($urandom_range(0, 7) == 0);
        alu_data  = $urandom;
      end
      if (!mem_valid || m_acc) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = rnd_idx();
        mem_data  = $urandom;
      end
      rr1 = rnd_idx();
      rr2 = rnd_idx();
    end
    idle(); reset = 1'b0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
